rr_arbiter8: RTL

- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Produces a one-hot grant plus a 3-bit binary grant index, the same encoding an 8x3 encoder produces for a one-hot input.
- Holds each grant until the owner signals done, or until a hold-timeout expires.
- Sits between requester blocks and the shared resource's select/mux logic.

---
 rtl/rr_arb_pkg.sv | 20 ++
 rtl/rr_pick8.sv | 38 +++
 rtl/rr_arbiter8.sv | 119 +++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states
// and the index-to-one-hot helper used when a grant is issued.
package rr_arb_pkg;

  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Expand a binary requester index into its one-hot grant vector.
  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin selector: rotates the request vector so that bit ptr lands at
// position 0, picks the lowest set bit, encodes it 8x3 and rotates the index
// back by adding ptr modulo 8.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     rot;
  logic [N-1:0]     first;
  logic [IDX_W-1:0] enc;

  // Doubling the vector turns the circular rotate into a plain part-select.
  assign req_dbl = {req, req};
  assign rot     = req_dbl[ptr +: N];

  // Isolate the lowest set bit of the rotated vector.
  assign first = rot & (-rot);

  // 8x3 one-hot encoder: OR together the indices of the set bits.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch can be inferred.
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (first[i]) enc = enc | IDX_W'(i);
    end
  end

  // Undo the rotation; the 3-bit add wraps modulo 8 naturally.
  assign sel = enc + ptr;
  assign any = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter. A grant is held until the owner
// raises done, drops its request, or has held the resource for MAX_HOLD
// cycles. Every grant is followed by at least one idle cycle, and the
// requester just served becomes lowest priority for the next arbitration.
module rr_arbiter8
  import rr_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  state_t           state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [N-1:0]     grant_d;
  logic [IDX_W-1:0] grant_idx_d;
  logic             grant_valid_d;
  logic             timeout_d;

  logic [IDX_W-1:0] sel;
  logic             any;
  logic             owner_release;
  logic             hit_max;
  logic             release_now;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  // A voluntary release (done, or the owner dropping its request) always
  // takes precedence over the hold limit, so timeout only fires without one.
  assign owner_release = done | ~req[grant_idx];
  assign hit_max       = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign release_now   = owner_release | hit_max;

  // State and registered outputs; reset is synchronous and clears everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      hold_cnt    <= hold_cnt_d;
      grant       <= grant_d;
      grant_idx   <= grant_idx_d;
      grant_valid <= grant_valid_d;
      timeout     <= timeout_d;
    end
  end

  // Next-state logic: arbitrate from IDLE, return to IDLE on any release.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any) state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath values to be registered at the next edge.
  always_comb begin
    ptr_d         = ptr;
    hold_cnt_d    = hold_cnt;
    grant_d       = grant;
    grant_idx_d   = grant_idx;
    grant_valid_d = grant_valid;
    timeout_d     = 1'b0;
    case (state)
      IDLE: begin
        hold_cnt_d = '0;
        if (any) begin
          grant_d       = onehot(sel);
          grant_idx_d   = sel;
          grant_valid_d = 1'b1;
        end else begin
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_now) begin
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
          ptr_d         = grant_idx + IDX_W'(1);
          timeout_d     = ~owner_release;
        end else begin
          hold_cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        grant_d       = '0;
        grant_idx_d   = '0;
        grant_valid_d = 1'b0;
        hold_cnt_d    = '0;
      end
    endcase
  end

endmodule
